mon_frame_tx: RTL

Serial frame transmitter for the host monitor. It sits directly downstream of the monitor FIFO. It pops one captured host-write record (11-bit address plus 18-bit data) at a time through the FIFO read handshake, packs the record into a fixed 6-byte frame, and shifts the frame out on `sout` as 8N1 UART. `sout` drives the debug serial link off-chip.

---
 rtl/mon_frame_tx_if.sv | 12 +
 rtl/mon_frame_tx.sv | 115 +++++++++++
 2 files changed

// File: rtl/mon_frame_tx_if.sv
// Read handshake between the monitor FIFO (slave) and the frame transmitter (master).
// rdreq stays high until a one-cycle rdack; raddr/rdata are valid only while rdack is high.
interface mon_frame_tx_if;
    logic        empty;
    logic        rdreq;
    logic        rdack;
    logic [10:0] raddr;
    logic [17:0] rdata;

    modport master (input empty, output rdreq, input rdack, input raddr, input rdata);
    modport slave  (output empty, input rdreq, output rdack, output raddr, output rdata);
endinterface

// File: rtl/mon_frame_tx.sv
// Pops one host-write record from the monitor FIFO and sends it as a 6-byte 8N1 UART frame
// (A5, addr hi, addr lo, data hi, data mid, data lo), LSB first, bytes back-to-back.
module mon_frame_tx #(
    parameter int unsigned DIV = 234
) (
    input  logic           clk,
    input  logic           rst_x,
    mon_frame_tx_if.master fifo,
    output logic           sout,
    output logic [1:0]     dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_q;
    logic        rdreq_q;
    logic        sout_q;
    logic [28:0] hold_q;
    logic [2:0]  byte_q;
    logic [3:0]  bit_q;
    logic [15:0] div_q;

    logic [2:0]  byte_d;
    logic [3:0]  bit_d;
    logic [7:0]  tx_byte;
    logic        frame_last;
    logic        sout_d;

    // sout is registered, so the bit value is computed for the position being entered.
    always_comb begin
        bit_d      = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
        byte_d     = (bit_q == 4'd9) ? byte_q + 3'd1 : byte_q;
        frame_last = (bit_q == 4'd9) && (byte_q == 3'd5);
        case (byte_d)
            3'd1:    tx_byte = {5'b0, hold_q[28:26]};
            3'd2:    tx_byte = hold_q[25:18];
            3'd3:    tx_byte = {6'b0, hold_q[17:16]};
            3'd4:    tx_byte = hold_q[15:8];
            3'd5:    tx_byte = hold_q[7:0];
            default: tx_byte = 8'hA5;
        endcase
        if (bit_d == 4'd0) begin
            sout_d = 1'b0;
        end else if (bit_d == 4'd9) begin
            sout_d = 1'b1;
        end else begin
            sout_d = tx_byte[3'(bit_d - 4'd1)];
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q <= S_IDLE;
            rdreq_q <= 1'b0;
            sout_q  <= 1'b1;
            hold_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rdreq_q <= 1'b0;
                    sout_q  <= 1'b1;
                    if (!fifo.empty) begin
                        state_q <= S_REQ;
                        rdreq_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (fifo.rdack) begin
                        hold_q  <= {fifo.raddr, fifo.rdata};
                        byte_q  <= '0;
                        bit_q   <= '0;
                        div_q   <= '0;
                        rdreq_q <= 1'b0;
                        sout_q  <= 1'b0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (frame_last) begin
                            state_q <= S_IDLE;
                            sout_q  <= 1'b1;
                            bit_q   <= '0;
                            byte_q  <= '0;
                        end else begin
                            bit_q  <= bit_d;
                            byte_q <= byte_d;
                            sout_q <= sout_d;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rdreq_q <= 1'b0;
                    sout_q  <= 1'b1;
                end
            endcase
        end
    end

    assign fifo.rdreq = rdreq_q;
    assign sout       = sout_q;
    assign dbg_state  = state_q;
endmodule
